// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed scan controller for a common-anode seven-segment display
// Drives one shared hex decoder with per-digit dead time and a per-frame input snapshot.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  input  logic        lzb,
  output logic [3:0]  nibble,
  output logic        hex_en,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  logic [15:0]   s_value;
  logic [3:0]    s_en;
  logic [3:0]    s_dp;
  logic          s_lzb;

  logic          snap_now;
  logic [15:0]   n_value;
  logic [3:0]    n_en;
  logic [3:0]    n_dp;
  logic          n_lzb;
  logic [3:0]    tail_zero;
  logic          tz_acc;
  logic          visible;
  logic [3:0]    cur_nibble;

  // Digit 0's outputs are registered on the snapshot edge itself, so they must
  // be computed from the values being captured rather than the stale snapshot.
  always_comb begin
    snap_now = (state == ST_BLANK) && (cnt == BLANK_LAST) && (idx == 2'd0);
    n_value  = snap_now ? value    : s_value;
    n_en     = snap_now ? digit_en : s_en;
    n_dp     = snap_now ? dp_in    : s_dp;
    n_lzb    = snap_now ? lzb      : s_lzb;

    tail_zero = 4'b0000;
    tz_acc    = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      if (d < NUM_DIGITS) begin
        tz_acc = tz_acc & (n_value[4*d +: 4] == 4'h0);
      end
      tail_zero[d] = tz_acc;
    end

    cur_nibble = n_value[{idx, 2'b00} +: 4];
    visible    = n_en[idx] && !(n_lzb && (idx != 2'd0) && tail_zero[idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      an         <= 4'b1111;
      hex_en     <= 1'b0;
      nibble     <= 4'h0;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      s_value    <= 16'h0000;
      s_en       <= 4'h0;
      s_dp       <= 4'h0;
      s_lzb      <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state  <= ST_SHOW;
            cnt    <= '0;
            an     <= visible ? ~(4'b0001 << idx) : 4'b1111;
            hex_en <= visible;
            nibble <= cur_nibble;
            dp     <= visible ? ~n_dp[idx] : 1'b1;
            if (snap_now) begin
              s_value    <= value;
              s_en       <= digit_en;
              s_dp       <= dp_in;
              s_lzb      <= lzb;
              frame_tick <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            idx    <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
            an     <= 4'b1111;
            hex_en <= 1'b0;
            dp     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_BLANK;
          idx    <= 2'd0;
          cnt    <= '0;
          an     <= 4'b1111;
          hex_en <= 1'b0;
          dp     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
// Expected per-clock outputs are queued per frame and popped on each falling edge.
module tb_seg_scan_ctrl;

  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int ND    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lzb = 1'b0;
  logic [3:0]  nibble;
  logic        hex_en;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       nchk;
    logic       hex_en;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SHOW),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .digit_en  (digit_en),
    .dp_in     (dp_in),
    .lzb       (lzb),
    .nibble    (nibble),
    .hex_en    (hex_en),
    .an        (an),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (($countones(~an) > 1) || (hex_en !== ($countones(~an) == 1))) begin
        errors++;
        $display("FAIL anode_invariant an=%b hex_en=%b", an, hex_en);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (an !== e.an || hex_en !== e.hex_en || dp !== e.dp || frame_tick !== e.ft ||
            (e.nchk && nibble !== e.nib)) begin
          errors++;
          $display("FAIL scoreboard got an=%b nib=%h hex_en=%b dp=%b ft=%b required an=%b nib=%h hex_en=%b dp=%b ft=%b",
                   an, nibble, hex_en, dp, frame_tick, e.an, e.nib, e.hex_en, e.dp, e.ft);
        end
      end
    end
  end

  task automatic set_in(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpi, input logic lz);
    value    = v;
    digit_en = en;
    dp_in    = dpi;
    lzb      = lz;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpi, input logic lz);
    logic tail;
    logic vis;
    exp_t x;
    for (int d = 0; d < ND; d++) begin
      tail = 1'b1;
      for (int k = d; k < ND; k++) begin
        if (v[4*k +: 4] != 4'h0) tail = 1'b0;
      end
      vis = en[d] && !(lz && (d != 0) && tail);
      for (int i = 0; i < BLANK; i++) begin
        x = '{an: 4'b1111, nib: 4'h0, nchk: 1'b0, hex_en: 1'b0, dp: 1'b1, ft: 1'b0};
        exp_q.push_back(x);
      end
      for (int i = 0; i < SHOW; i++) begin
        x.an     = vis ? ~(4'b0001 << d) : 4'b1111;
        x.nib    = v[4*d +: 4];
        x.nchk   = 1'b1;
        x.hex_en = vis;
        x.dp     = vis ? ~dpi[d] : 1'b1;
        x.ft     = (d == 0) && (i == 0);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic wait_left(input int n);
    int t;
    t = 0;
    while (exp_q.size() > n && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL drain_timeout left=%0d required<=%0d", exp_q.size(), n);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(16'h1234, 4'hF, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b required=1111", an); end
    checks++; if (hex_en !== 1'b0) begin errors++; $display("FAIL reset_hex_en got=%b required=0", hex_en); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got=%h required=0", nibble); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b required=1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b required=0", frame_tick); end
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0);
    release_reset();
    wait_left(0);
  endtask

  task automatic test_no_tear();
    set_in(16'h1234, 4'hF, 4'h0, 1'b0);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0);
    wait_left(8);
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL tear_slot_an got=%b required=1011", an); end
    value = 16'hABCD;
    checks++; if (nibble !== 4'h2) begin errors++; $display("FAIL tear_slot_nibble got=%h required=2", nibble); end
    wait_left(0);
    push_frame(16'hABCD, 4'hF, 4'h0, 1'b0);
    wait_left(0);
  endtask

  task automatic test_lzb();
    set_in(16'h0050, 4'hF, 4'h0, 1'b1);
    push_frame(16'h0050, 4'hF, 4'h0, 1'b1);
    wait_left(0);
    set_in(16'h0000, 4'hF, 4'h0, 1'b1);
    push_frame(16'h0000, 4'hF, 4'h0, 1'b1);
    wait_left(0);
  endtask

  task automatic test_digit_en_dp();
    set_in(16'h1234, 4'b1010, 4'b0010, 1'b0);
    push_frame(16'h1234, 4'b1010, 4'b0010, 1'b0);
    wait_left(0);
  endtask

  task automatic test_async_reset();
    set_in(16'h1234, 4'hF, 4'h0, 1'b0);
    push_frame(16'h1234, 4'hF, 4'h0, 1'b0);
    wait_left(8);
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL pre_reset_an got=%b required=1011", an); end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_reset_an got=%b required=1111", an); end
    checks++; if (hex_en !== 1'b0) begin errors++; $display("FAIL async_reset_hex_en got=%b required=0", hex_en); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_reset_dp got=%b required=1", dp); end
    set_in(16'h5A0F, 4'hF, 4'b0101, 1'b0);
    push_frame(16'h5A0F, 4'hF, 4'b0101, 1'b0);
    release_reset();
    wait_left(0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [3:0]  en;
    logic [3:0]  dpi;
    logic        lz;
    for (int f = 0; f < 6; f++) begin
      v   = 16'($urandom_range(0, 65535));
      if (f == 2) v = v & 16'h00F0;
      en  = 4'($urandom_range(0, 15));
      dpi = 4'($urandom_range(0, 15));
      lz  = 1'($urandom_range(0, 1));
      set_in(v, en, dpi, lz);
      push_frame(v, en, dpi, lz);
      wait_left(0);
    end
  endtask

  initial begin
    test_reset();
    test_no_tear();
    test_lzb();
    test_digit_en_dp();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
